// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path: the drain FSM state
// encoding used by tx_byte_buffer and the WAIT_BUSY timeout constant.
// ---------------------------------------------------------------------------
package uart_pkg;

  // Drain FSM states of the transmit byte buffer.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } drainState_e;

  // Consecutive idle isBusy cycles after which a launch is treated as
  // consumed even though the sender never acknowledged it.
  localparam int BUSY_TIMEOUT = 4;
  localparam int TIMER_W      = $clog2(BUSY_TIMEOUT);

endpackage

// File: rtl/byte_fifo.sv
// ---------------------------------------------------------------------------
// byte_fifo
// Circular FIFO storage with wrapping read/write pointers. The caller is
// responsible for qualifying pushEn/popEn (no push when full unless popping,
// no pop when empty).
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-low reset
//   pushEn   in   store dataIn at the write pointer this cycle
//   popEn    in   advance the read pointer this cycle
//   dataIn   in   byte to store
//   headData out  entry at the read pointer (oldest stored byte)
//   count    out  number of stored entries
//   full     out  count == DEPTH
//   empty    out  count == 0
// ---------------------------------------------------------------------------
module byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pushEn,
  input  logic                   popEn,
  input  logic [WIDTH-1:0]       dataIn,
  output logic [WIDTH-1:0]       headData,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;

  // NOTE: storage is written without a reset; only pointers and count define
  // which entries are valid, so clearing the array would buy nothing.
  always_ff @(posedge clk) begin
    if (pushEn) begin
      mem[wrPtr] <= dataIn;
    end
  end

  // Pointers are exactly log2(DEPTH) bits, so the +1 wraps DEPTH-1 -> 0.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushEn) wrPtr <= wrPtr + 1'b1;
      if (popEn)  rdPtr <= rdPtr + 1'b1;
      case ({pushEn, popEn})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign headData = mem[rdPtr];
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/tx_byte_buffer.sv
// ---------------------------------------------------------------------------
// tx_byte_buffer
// Buffers result bytes from dNNProcessingElement and drains them one at a
// time into Sender_V. Each byte is popped into the TxData register, launched
// with a one-cycle doTransmit, and the FSM then waits for the sender to go
// busy and idle again. If the sender never raises isBusy within
// BUSY_TIMEOUT cycles, the byte is considered consumed and not resent.
//
// Ports
//   clk        in   system (divided) clock, rising edge
//   reset      in   asynchronous active-low reset
//   dataIn     in   result byte from the processing element
//   inValid    in   one-cycle write strobe (PE doTransmit)
//   full       out  FIFO holds DEPTH entries
//   count      out  number of stored entries
//   overflow   out  sticky: a write was dropped because the FIFO was full
//   isBusy     in   busy flag from the UART sender
//   TxData     out  byte presented to the UART sender
//   doTransmit out  one-cycle launch strobe to the UART sender
// ---------------------------------------------------------------------------
module tx_byte_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       dataIn,
  input  logic                   inValid,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   isBusy,
  output logic [WIDTH-1:0]       TxData,
  output logic                   doTransmit
);

  drainState_e        state;
  drainState_e        nextState;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] nextTimer;
  logic               popEn;
  logic               pushEn;
  logic               empty;
  logic [WIDTH-1:0]   headData;

  // A full FIFO still accepts a byte when the drain pops in the same cycle,
  // because the write lands in the slot the pop frees.
  assign pushEn = inValid && (!full || popEn);

  byte_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .pushEn   (pushEn),
    .popEn    (popEn),
    .dataIn   (dataIn),
    .headData (headData),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    nextState = state;
    nextTimer = '0;
    popEn     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !isBusy) begin
          popEn     = 1'b1;
          nextState = LAUNCH;
        end
      end
      LAUNCH: begin
        nextState = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // Any isBusy=1 leaves this state, so the timer only ever counts
        // consecutive idle cycles.
        if (isBusy) begin
          nextState = WAIT_DONE;
        end else if (timer == TIMER_W'(BUSY_TIMEOUT - 1)) begin
          nextState = IDLE;
        end else begin
          nextTimer = timer + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!isBusy) nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= nextState;
      timer <= nextTimer;
    end
  end

  // TxData holds the popped byte until the next pop replaces it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      TxData <= '0;
    end else if (popEn) begin
      TxData <= headData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (inValid && full && !popEn) begin
      overflow <= 1'b1;
    end
  end

  // Decoded from the registered state, so the strobe is glitch-free and
  // exactly one cycle wide.
  assign doTransmit = (state == LAUNCH);

endmodule

// File: tb/tb_tx_byte_buffer.sv
// ---------------------------------------------------------------------------
// tb_tx_byte_buffer
// Scoreboard bench: accepted writes push the expected byte into a queue; a
// monitor pops and compares whenever doTransmit is seen. A behavioural
// sender model drives isBusy.
// ---------------------------------------------------------------------------
module tb_tx_byte_buffer;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] dataIn;
  logic             inValid;
  logic             full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             isBusy = 1'b0;
  logic [WIDTH-1:0] TxData;
  logic             doTransmit;

  always #5 clk = ~clk;

  tx_byte_buffer #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .dataIn     (dataIn),
    .inValid    (inValid),
    .full       (full),
    .count      (count),
    .overflow   (overflow),
    .isBusy     (isBusy),
    .TxData     (TxData),
    .doTransmit (doTransmit)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: bytes expected on TxData in order, and occupancy as
  // seen from the write side (decremented when a launch is observed).
  logic [WIDTH-1:0] expQ[$];
  int modelCount   = 0;
  int pulseCount   = 0;
  int cyc          = 0;
  int lastPulseCyc = 0;
  int prevPulseCyc = 0;

  // Sender model: 0 = isBusy tied low, 1 = tied high, 2 = goes busy for
  // busyLen cycles (or a random length) after each launch.
  int busyMode  = 0;
  int busyLen   = 0;
  int busyTimer = 0;
  bit randLen   = 1'b0;
  int newLen;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reset && doTransmit) begin
      pulseCount++;
      prevPulseCyc = lastPulseCyc;
      lastPulseCyc = cyc;
      check("busy_at_launch", isBusy, 0);
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: TxData 0x%0h launched, no byte expected", TxData);
      end else begin
        check("tx_order", TxData, expQ.pop_front());
        modelCount--;
      end
    end
    case (busyMode)
      0: isBusy = 1'b0;
      1: isBusy = 1'b1;
      default: begin
        if (busyTimer > 0) begin
          busyTimer--;
          if (busyTimer == 0) isBusy = 1'b0;
        end else if (reset && doTransmit) begin
          newLen = randLen ? int'($urandom_range(0, 6)) : busyLen;
          if (newLen > 0) begin
            isBusy    = 1'b1;
            busyTimer = newLen;
          end
        end else begin
          isBusy = 1'b0;
        end
      end
    endcase
  end

  task automatic drive(input bit v, input logic [WIDTH-1:0] b);
    @(posedge clk);
    #1;
    inValid = v;
    dataIn  = b;
  endtask

  // Without a concurrent pop a write is kept only while there is room.
  task automatic pushByte(input logic [WIDTH-1:0] b);
    drive(1'b1, b);
    if (modelCount < DEPTH) begin
      expQ.push_back(b);
      modelCount++;
    end
  endtask

  task automatic waitDrain(input int maxCyc, input string name);
    int n = 0;
    while (expQ.size() != 0 && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    check(name, expQ.size(), 0);
  endtask

  task automatic applyReset();
    #3;
    reset     = 1'b0;
    inValid   = 1'b0;
    busyMode  = 0;
    busyTimer = 0;
    #1;
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_txdata", TxData, 0);
    check("rst_dotransmit", doTransmit, 0);
    expQ.delete();
    modelCount = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int pushCyc;
    int p0;
    int n;

    reset   = 1'b0;
    inValid = 1'b0;
    dataIn  = '0;
    #2;
    check("init_count", count, 0);
    check("init_full", full, 0);
    check("init_overflow", overflow, 0);
    check("init_txdata", TxData, 0);
    check("init_dotransmit", doTransmit, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Single byte, latency 2 and no resend after the busy timeout.
    busyMode = 0;
    p0 = pulseCount;
    pushByte(8'hA5);
    pushCyc = cyc;
    drive(1'b0, '0);
    waitDrain(20, "single_drain");
    check("single_latency", lastPulseCyc - pushCyc, 2);
    repeat (20) @(negedge clk);
    check("single_pulses", pulseCount - p0, 1);
    check("single_count", count, 0);

    // Back-to-back bytes with isBusy tied low: each launch waits out the
    // 4-cycle timeout, so IDLE is reached 5 cycles after LAUNCH and the
    // next launch follows one cycle later.
    p0 = pulseCount;
    pushByte(8'h3C);
    pushByte(8'h3D);
    drive(1'b0, '0);
    waitDrain(40, "timeout_drain");
    check("timeout_gap", lastPulseCyc - prevPulseCyc, 6);
    repeat (20) @(negedge clk);
    check("timeout_pulses", pulseCount - p0, 2);

    // Burst into a slow sender.
    busyMode = 2;
    busyLen  = 10;
    p0 = pulseCount;
    for (int i = 1; i <= 5; i++) pushByte(WIDTH'(i));
    drive(1'b0, '0);
    waitDrain(200, "burst_drain");
    repeat (15) @(negedge clk);
    check("burst_pulses", pulseCount - p0, 5);
    check("burst_count", count, 0);

    // Overflow with the sender held busy.
    busyMode = 1;
    repeat (2) @(posedge clk);
    p0 = pulseCount;
    for (int i = 0; i < DEPTH; i++) pushByte(WIDTH'(8'h40 + i));
    drive(1'b0, '0);
    @(negedge clk);
    check("ovf_full", full, 1);
    check("ovf_count16", count, DEPTH);
    check("ovf_not_yet", overflow, 0);
    pushByte(8'h99);
    drive(1'b0, '0);
    @(negedge clk);
    check("ovf_set", overflow, 1);
    check("ovf_count_held", count, DEPTH);
    busyMode = 2;
    busyLen  = 2;
    waitDrain(400, "ovf_drain");
    repeat (20) @(negedge clk);
    check("ovf_pulses", pulseCount - p0, DEPTH);
    check("ovf_sticky", overflow, 1);
    check("ovf_count_empty", count, 0);
    check("ovf_full_clear", full, 0);
    applyReset();
    check("ovf_cleared_by_reset", overflow, 0);

    // Full FIFO with a pop and a write in the same cycle.
    busyMode = 1;
    repeat (2) @(posedge clk);
    p0 = pulseCount;
    for (int i = 0; i < DEPTH; i++) pushByte(WIDTH'(8'h60 + i));
    drive(1'b0, '0);
    @(negedge clk);
    check("simul_full", full, 1);
    // Releasing the sender here makes isBusy low at the next negedge, so the
    // drain pops at the same edge that captures 0x7E.
    @(posedge clk);
    #1;
    inValid  = 1'b1;
    dataIn   = 8'h7E;
    busyMode = 2;
    busyLen  = 3;
    expQ.push_back(8'h7E);
    modelCount++;
    drive(1'b0, '0);
    @(negedge clk);
    check("simul_count", count, DEPTH);
    check("simul_overflow", overflow, 0);
    check("simul_launch", doTransmit, 1);
    waitDrain(400, "simul_drain");
    repeat (10) @(negedge clk);
    check("simul_pulses", pulseCount - p0, DEPTH + 1);
    check("simul_overflow_end", overflow, 0);

    // Reset while the sender is busy with the first of three bytes.
    busyMode = 2;
    busyLen  = 10;
    p0 = pulseCount;
    for (int i = 0; i < 3; i++) pushByte(WIDTH'(8'hC0 + i));
    drive(1'b0, '0);
    n = 0;
    while (pulseCount == p0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_first_launch", pulseCount - p0, 1);
    repeat (3) @(negedge clk);
    check("mid_busy", isBusy, 1);
    applyReset();
    p0 = pulseCount;
    repeat (30) @(negedge clk);
    check("mid_no_pulse_after_reset", pulseCount - p0, 0);
    check("mid_count_after_reset", count, 0);
    pushByte(8'h5A);
    drive(1'b0, '0);
    waitDrain(20, "mid_new_byte");
    check("mid_new_pulse", pulseCount - p0, 1);

    // Randomized traffic against a sender with random busy lengths.
    busyMode = 2;
    randLen  = 1'b1;
    repeat (300) begin
      if (modelCount < DEPTH - 2 && $urandom_range(0, 2) == 0)
        pushByte(WIDTH'($urandom));
      else
        drive(1'b0, '0);
    end
    drive(1'b0, '0);
    waitDrain(3000, "rand_drain");
    repeat (15) @(negedge clk);
    check("rand_count", count, 0);
    check("rand_full", full, 0);
    check("rand_overflow", overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_byte_buffer.md
TX_BYTE_BUFFER -- requirements
Module: tx_byte_buffer

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; power of two, at least 2.
REQ-002 Parameter WIDTH, default 8, byte width carried to the UART sender.
REQ-003 Port clk, input, 1: single system clock (divided clock); all state updates on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset; reset=0 clears all state immediately.
REQ-005 Port dataIn, input, WIDTH: result byte from the DNN processing element.
REQ-006 Port inValid, input, 1: one-cycle write strobe, driven by the PE's doTransmit.
REQ-007 Port full, output, 1: high when the FIFO holds DEPTH entries.
REQ-008 Port count, output, log2(DEPTH)+1: number of stored entries.
REQ-009 Port overflow, output, 1: sticky flag, set when a write is dropped.
REQ-010 Port isBusy, input, 1: busy flag from the UART sender.
REQ-011 Port TxData, output, WIDTH: byte presented to the UART sender.
REQ-012 Port doTransmit, output, 1: one-cycle launch strobe to the UART sender.

Function
REQ-013 The block SHALL be a circular FIFO with read/write pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-014 A write SHALL occur when inValid=1 and either full=0 or a pop happens in the same cycle.
REQ-015 When inValid=1, full=1 and no pop happens in that cycle, the byte SHALL be dropped and overflow SHALL be set to 1; overflow SHALL clear only on reset.
REQ-016 The drain FSM SHALL have four states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-017 IDLE -> LAUNCH when count>0 and isBusy=0; in that cycle the head entry is popped into the TxData register.
REQ-018 In LAUNCH, doTransmit SHALL be 1 for exactly one cycle; the next state is WAIT_BUSY.
REQ-019 WAIT_BUSY -> WAIT_DONE when isBusy=1.
REQ-019a WAIT_BUSY -> IDLE when isBusy has stayed 0 for 4 consecutive cycles; the byte counts as consumed and is not resent.
REQ-020 WAIT_DONE -> IDLE when isBusy=0.
REQ-021 TxData SHALL hold its value from the pop until the next pop.
REQ-022 Latency SHALL be 2 clk cycles from a write into an empty FIFO (with FSM in IDLE and isBusy=0) to doTransmit=1.
REQ-023 count SHALL update in the cycle after a write or pop; when a write and a pop happen together, count SHALL stay unchanged.
REQ-024 A pop SHALL never happen while count=0; doTransmit SHALL never be 1 outside LAUNCH.
REQ-025 Bytes SHALL reach TxData in exactly the order they were written.

Reset
REQ-026 On reset=0, without waiting for a clock edge:
- pointers=0, count=0, full=0, overflow=0
- TxData=0, doTransmit=0
- FSM=IDLE, timeout counter=0
REQ-027 Asserting reset mid-transfer SHALL discard all stored bytes; no doTransmit SHALL occur until a new write follows reset release.
REQ-028 FIFO storage array contents need not be reset.

Structure
REQ-029 The FSM state encoding and the WAIT_BUSY timeout constant (4) SHALL live in a shared package, uart_pkg.
REQ-030 Storage and pointers SHALL be one sub-module, byte_fifo; the drain FSM and output registers SHALL be top level.
REQ-031 The block SHALL sit between dNNProcessingElement (dataOut, doTransmit) and Sender_V (TxData, doTransmit, isBusy).

Verification
REQ-032 Single byte: write 0xA5 into empty FIFO, isBusy=0 -> doTransmit pulses 2 cycles later with TxData=0xA5; count returns to 0.
REQ-033 Burst, slow sender: write 0x01..0x05 on consecutive cycles; model isBusy=1 for 10 cycles per launch -> exactly 5 doTransmit pulses, in order 0x01..0x05, none while isBusy=1.
REQ-034 Overflow, DEPTH=16, isBusy held 1:
- write 17 bytes -> full=1 after the 16th and overflow=1 after the 17th
- release isBusy -> 16 bytes drain and the 17th is never sent
REQ-035 Full with simultaneous pop: FIFO full, a pop and a write of 0x7E in the same cycle -> count stays 16, overflow stays 0, and 0x7E later drains last.
REQ-036 Busy timeout: isBusy tied 0, write 0x3C -> one pulse, FSM back in IDLE 5 cycles after LAUNCH, no resend.
REQ-037 Reset mid-drain: 3 bytes queued, assert reset in WAIT_DONE -> all outputs 0 immediately, no further doTransmit after release until new data is written.
